// File: rtl/ramp_relock_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ramp_relock_arbiter_pkg
// Description : Shared definitions for the ramp relock arbiter: FSM state
//               encoding, grant source indices and a one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ramp_relock_arbiter_pkg;

    // FSM encoding; the numeric values are visible on the debug word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_e;

    // Grant source indices; also the bit positions inside the gnt vector.
    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] MAN = 2'd2;

    function automatic logic [2:0] src_onehot(input logic [1:0] src);
        return 3'b001 << src;
    endfunction

    // Per-channel mask for a relock source (manual maps to no channel).
    function automatic logic [1:0] chan_mask(input logic [1:0] src);
        logic [1:0] m;
        m = 2'b00;
        if (src == CH0) m = 2'b01;
        if (src == CH1) m = 2'b10;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_relock_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : ramp_relock_arbiter_rr_pick2
// Description : Combinational two-way round-robin pick between the relock
//               channels.
// Ports       : ereq_i    - effective requests {ch1, ch0}
//               ptr_i     - current pointer (0 = ch0 preferred on a tie)
//               pick_o    - one-hot pick {ch1, ch0}, zero when no request
//               ptr_nxt_o - pointer to store when the pick is granted
// Revision    : 1.0 - initial release
// ============================================================================
module ramp_relock_arbiter_rr_pick2
    import ramp_relock_arbiter_pkg::*;
(
    input  logic [1:0] ereq_i,
    input  logic       ptr_i,
    output logic [1:0] pick_o,
    output logic       ptr_nxt_o
);

    always_comb begin
        pick_o    = 2'b00;
        ptr_nxt_o = ptr_i;
        case (ereq_i)
            // Tie: the pointer names the winner, then moves to the loser.
            2'b11: begin
                pick_o    = ptr_i ? 2'b10 : 2'b01;
                ptr_nxt_o = ~ptr_i;
            end
            // Single requester: pointer moves to the other channel.
            2'b01: begin
                pick_o    = 2'b01;
                ptr_nxt_o = 1'b1;
            end
            2'b10: begin
                pick_o    = 2'b10;
                ptr_nxt_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ramp_relock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ramp_relock_arbiter
// Description : Shares one ramp generator between two relock controllers and
//               a manual scan request. Relock wins over manual, relock
//               channels alternate round-robin, a guard gap separates grants
//               and a programmable timeout stops a stuck relock owner.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req0_i/req1_i       - relock requests (level)
//               req_man_i           - manual scan request
//               low*/hig*_i         - signed scan limits per source
//               tmo_limit_i         - relock grant limit in cycles (0 = off)
//               clear_flags_i       - clears the sticky timeout flags
//               gnt_o               - one-hot grant {man, ch1, ch0}
//               ramp_run_o          - ramp generator run enable
//               ramp_low/hig_o      - scan limits to the ramp generator
//               tmo_flag_o          - sticky timeout flag per channel
//               state_dbg_o         - {0, state, pointer, zeros}
// Revision    : 1.0 - initial release
// ============================================================================
module ramp_relock_arbiter
    import ramp_relock_arbiter_pkg::*;
#(
    parameter int R         = 14,
    parameter int TMO_W     = 27,
    parameter int GUARD_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_i,
    input  logic                 req1_i,
    input  logic                 req_man_i,
    input  logic signed [R-1:0]  low0_i,
    input  logic signed [R-1:0]  hig0_i,
    input  logic signed [R-1:0]  low1_i,
    input  logic signed [R-1:0]  hig1_i,
    input  logic signed [R-1:0]  low_man_i,
    input  logic signed [R-1:0]  hig_man_i,
    input  logic [TMO_W-1:0]     tmo_limit_i,
    input  logic                 clear_flags_i,
    output logic [2:0]           gnt_o,
    output logic                 ramp_run_o,
    output logic signed [R-1:0]  ramp_low_o,
    output logic signed [R-1:0]  ramp_hig_o,
    output logic [1:0]           tmo_flag_o,
    output logic [R-1:0]         state_dbg_o
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    state_e              state_q, state_d;
    logic [1:0]          src_q, src_d;
    logic                ptr_q, ptr_d;
    logic [2:0]          gnt_q, gnt_d;
    logic                run_q, run_d;
    logic signed [R-1:0] low_q, low_d;
    logic signed [R-1:0] hig_q, hig_d;
    logic [1:0]          flag_q, flag_d;
    logic [1:0]          blk_q, blk_d;
    logic                tmo_hit_q, tmo_hit_d;
    logic [GW-1:0]       guard_cnt_q, guard_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic [1:0]          w_ereq;
    logic [1:0]          w_pick;
    logic                w_ptr_nxt;
    logic                w_src_req;
    logic [TMO_W:0]      w_tmo_cnt_inc;
    logic                w_tmo_expired;
    logic [1:0]          w_tmo_set;
    logic signed [R-1:0] w_src_low;
    logic signed [R-1:0] w_src_hig;

    // A timed-out channel stays blocked until it drops its request once.
    assign w_ereq = {req1_i, req0_i} & ~blk_q;

    ramp_relock_arbiter_rr_pick2 u_pick (
        .ereq_i    (w_ereq),
        .ptr_i     (ptr_q),
        .pick_o    (w_pick),
        .ptr_nxt_o (w_ptr_nxt)
    );

    always_comb begin
        w_src_req = req_man_i;
        w_src_low = low_man_i;
        w_src_hig = hig_man_i;
        if (src_q == CH0) begin
            w_src_req = req0_i;
            w_src_low = low0_i;
            w_src_hig = hig0_i;
        end else if (src_q == CH1) begin
            w_src_req = req1_i;
            w_src_low = low1_i;
            w_src_hig = hig1_i;
        end
    end

    // tmo_cnt_q holds the number of completed grant cycles, so the current
    // cycle is number tmo_cnt_q+1; one extra bit keeps the compare exact.
    assign w_tmo_cnt_inc = {1'b0, tmo_cnt_q} + {{TMO_W{1'b0}}, 1'b1};
    assign w_tmo_expired = (state_q == GRANT) && (src_q != MAN) &&
                           (tmo_limit_i != '0) &&
                           (w_tmo_cnt_inc >= {1'b0, tmo_limit_i});

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        ptr_d       = ptr_q;
        guard_cnt_d = guard_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_hit_d   = 1'b0;
        w_tmo_set   = 2'b00;

        case (state_q)
            IDLE: begin
                if (w_ereq != 2'b00) begin
                    state_d   = GRANT;
                    src_d     = (w_pick == 2'b10) ? CH1 : CH0;
                    ptr_d     = w_ptr_nxt;
                    tmo_cnt_d = '0;
                end else if (req_man_i) begin
                    state_d   = GRANT;
                    src_d     = MAN;
                    tmo_cnt_d = '0;
                end
            end
            GRANT: begin
                tmo_cnt_d = w_tmo_cnt_inc[TMO_W-1:0];
                if (w_tmo_expired) begin
                    tmo_hit_d = 1'b1;
                    w_tmo_set = chan_mask(src_q);
                end
                if (!w_src_req || ((src_q == MAN) && (w_ereq != 2'b00)) ||
                    w_tmo_expired) begin
                    state_d     = GUARD;
                    guard_cnt_d = '0;
                end
            end
            GUARD: begin
                if (guard_cnt_q == GW'(GUARD_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the current state, so they trail the
        // FSM by one cycle on both grant and release.
        gnt_d = (state_q == GRANT) ? src_onehot(src_q) : 3'b000;
        run_d = (state_q == GRANT);
        low_d = (state_q == GRANT) ? w_src_low : low_q;
        hig_d = (state_q == GRANT) ? w_src_hig : hig_q;

        // The flag is set one edge after the timeout decision, which lines
        // it up with the falling edge of gnt; a set beats a clear.
        flag_d = (clear_flags_i ? 2'b00 : flag_q) |
                 (tmo_hit_q ? chan_mask(src_q) : 2'b00);

        // A channel with its request low is unblocked in that same cycle.
        blk_d = {req1_i, req0_i} & (blk_q | w_tmo_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= CH0;
            ptr_q       <= 1'b0;
            gnt_q       <= 3'b000;
            run_q       <= 1'b0;
            low_q       <= '0;
            hig_q       <= '0;
            flag_q      <= 2'b00;
            blk_q       <= 2'b00;
            tmo_hit_q   <= 1'b0;
            guard_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            run_q       <= run_d;
            low_q       <= low_d;
            hig_q       <= hig_d;
            flag_q      <= flag_d;
            blk_q       <= blk_d;
            tmo_hit_q   <= tmo_hit_d;
            guard_cnt_q <= guard_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ramp_run_o  = run_q;
    assign ramp_low_o  = low_q;
    assign ramp_hig_o  = hig_q;
    assign tmo_flag_o  = flag_q;
    assign state_dbg_o = {1'b0, state_q, ptr_q, {(R-4){1'b0}}};

endmodule
`default_nettype wire

// File: tb/tb_ramp_relock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ramp_relock_arbiter
// Description : Self-checking bench for ramp_relock_arbiter: a vector table
//               for the idle selection, directed multi-cycle sequences and a
//               randomized run against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ramp_relock_arbiter;

    localparam int R         = 14;
    localparam int TMO_W     = 27;
    localparam int GUARD_CYC = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0, req1, req_man;
    logic signed [R-1:0] low0, hig0, low1, hig1, low_man, hig_man;
    logic [TMO_W-1:0]    tmo_limit;
    logic                clear_flags;
    logic [2:0]          gnt;
    logic                ramp_run;
    logic signed [R-1:0] ramp_low, ramp_hig;
    logic [1:0]          tmo_flag;
    logic [R-1:0]        state_dbg;

    always #5 clk = ~clk;

    ramp_relock_arbiter #(.R(R), .TMO_W(TMO_W), .GUARD_CYC(GUARD_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_i        (req0),
        .req1_i        (req1),
        .req_man_i     (req_man),
        .low0_i        (low0),
        .hig0_i        (hig0),
        .low1_i        (low1),
        .hig1_i        (hig1),
        .low_man_i     (low_man),
        .hig_man_i     (hig_man),
        .tmo_limit_i   (tmo_limit),
        .clear_flags_i (clear_flags),
        .gnt_o         (gnt),
        .ramp_run_o    (ramp_run),
        .ramp_low_o    (ramp_low),
        .ramp_hig_o    (ramp_hig),
        .tmo_flag_o    (tmo_flag),
        .state_dbg_o   (state_dbg)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [63:0] ext(input logic [R-1:0] v);
        return {{(64-R){1'b0}}, v};
    endfunction

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 someone owns the ramp, 2 guard gap. Outputs are what
    // an observer sees after the edge: who owned the ramp during the cycle
    // that just ended.
    int                  m_phase, m_owner, m_held, m_guard_left, m_pend;
    bit                  m_ptr;
    bit [1:0]            m_blk, m_flag;
    bit [2:0]            e_gnt;
    bit                  e_run;
    logic signed [R-1:0] e_low, e_hig;

    function automatic logic signed [R-1:0] lim(input int who, input bit hi);
        if (who == 0) return hi ? hig0 : low0;
        if (who == 1) return hi ? hig1 : low1;
        return hi ? hig_man : low_man;
    endfunction

    task automatic model_step();
        bit [2:0] rq;
        bit [1:0] er, to;
        rq = {req_man, req1, req0};
        er = rq[1:0] & ~m_blk;
        to = 2'b00;
        if (rst) begin
            m_phase = 0; m_owner = 0; m_held = 0; m_guard_left = 0; m_pend = -1;
            m_ptr = 0; m_blk = 0; m_flag = 0;
            e_gnt = 0; e_run = 0; e_low = 0; e_hig = 0;
        end else begin
            if (m_phase == 1) begin
                e_gnt = 3'(1 << m_owner);
                e_run = 1;
                e_low = lim(m_owner, 0);
                e_hig = lim(m_owner, 1);
            end else begin
                e_gnt = 0;
                e_run = 0;
            end
            if (clear_flags) m_flag = 0;
            if (m_pend >= 0) m_flag[m_pend] = 1;
            m_pend = -1;
            if (m_phase == 0) begin
                if (er == 2'b11) begin
                    m_owner = m_ptr ? 1 : 0; m_ptr = ~m_ptr; m_phase = 1; m_held = 0;
                end else if (er != 2'b00) begin
                    m_owner = er[1] ? 1 : 0; m_ptr = er[1] ? 0 : 1; m_phase = 1; m_held = 0;
                end else if (rq[2]) begin
                    m_owner = 2; m_phase = 1; m_held = 0;
                end
            end else if (m_phase == 1) begin
                bit tmo;
                m_held++;
                tmo = (m_owner < 2) && (tmo_limit != 0) && (m_held >= int'(tmo_limit));
                if (tmo) begin
                    m_pend = m_owner;
                    to[m_owner] = 1;
                end
                if (!rq[m_owner] || (m_owner == 2 && er != 0) || tmo) begin
                    m_phase = 2; m_guard_left = GUARD_CYC;
                end
            end else begin
                m_guard_left--;
                if (m_guard_left == 0) m_phase = 0;
            end
            for (int k = 0; k < 2; k++) begin
                if (!rq[k]) m_blk[k] = 0;
                else if (to[k]) m_blk[k] = 1;
            end
        end
    endtask

    task automatic tick();
        logic [R-1:0] e_dbg;
        @(posedge clk);
        model_step();
        #1;
        e_dbg = {1'b0, 2'(m_phase), m_ptr, {(R-4){1'b0}}};
        chk("model", {gnt, ramp_run, ramp_low, ramp_hig, tmo_flag, state_dbg},
                     {e_gnt, e_run, e_low, e_hig, m_flag, e_dbg});
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic wait_gnt(input string name, input logic [2:0] want, input int budget);
        int n = 0;
        while (gnt !== want && n < budget) begin tick(); n++; end
        chk(name, {61'b0, gnt}, {61'b0, want});
    endtask

    // Counts gnt=0 cycles until the next grant shows up (bounded).
    task automatic count_gap(output int gap);
        int n = 0;
        gap = 0;
        do begin
            tick(); n++;
            if (gnt == 3'b000) gap++;
        end while (gnt == 3'b000 && n < 40);
    endtask

    typedef struct {
        bit       r0, r1, rm;
        bit [2:0] g;
        int       lo;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, cnt, bad;
        bit [2:0] own;

        tbl[0] = '{0, 0, 0, 3'b000, 0};
        tbl[1] = '{1, 0, 0, 3'b001, -10};
        tbl[2] = '{0, 1, 0, 3'b010, -20};
        tbl[3] = '{1, 1, 0, 3'b001, -10};
        tbl[4] = '{0, 0, 1, 3'b100, -30};
        tbl[5] = '{1, 0, 1, 3'b001, -10};
        tbl[6] = '{0, 1, 1, 3'b010, -20};
        tbl[7] = '{1, 1, 1, 3'b001, -10};

        rst = 1; req0 = 0; req1 = 0; req_man = 0; clear_flags = 0; tmo_limit = '0;
        low0 = -10; hig0 = 10; low1 = -20; hig1 = 20; low_man = -30; hig_man = 30;
        tick(); tick(); rst = 0;

        // Reset state
        chk("rst_gnt", {61'b0, gnt}, 64'd0);
        chk("rst_run", {63'b0, ramp_run}, 64'd0);
        chk("rst_low", ext(ramp_low), 64'd0);
        chk("rst_hig", ext(ramp_hig), 64'd0);
        chk("rst_flag", {62'b0, tmo_flag}, 64'd0);
        chk("rst_dbg", ext(state_dbg), 64'd0);

        // Idle selection table, each from reset (pointer at ch0)
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req0 = tbl[i].r0; req1 = tbl[i].r1; req_man = tbl[i].rm;
            tick(); tick();
            chk($sformatf("tbl%0d_gnt", i), {61'b0, gnt}, {61'b0, tbl[i].g});
            chk($sformatf("tbl%0d_low", i), ext(ramp_low), ext(R'(tbl[i].lo)));
            req0 = 0; req1 = 0; req_man = 0;
        end

        // Grant latency and limit tracking
        do_reset();
        low0 = -100; hig0 = 100; req0 = 1;
        tick(); tick();
        chk("lat_gnt", {61'b0, gnt}, 64'd1);
        chk("lat_run", {63'b0, ramp_run}, 64'd1);
        chk("lat_low", ext(ramp_low), ext(R'(-100)));
        chk("lat_hig", ext(ramp_hig), ext(R'(100)));
        hig0 = 200;
        tick();
        chk("track_hig", ext(ramp_hig), ext(R'(200)));
        req0 = 0;

        // Round robin between two held channels, 9-cycle gaps
        do_reset();
        req0 = 1; req1 = 1;
        for (int g = 0; g < 4; g++) begin
            if (g == 0) wait_gnt("rr_first", 3'b001, 10);
            else begin
                count_gap(gap);
                chk($sformatf("rr_gap%0d", g), gap, GUARD_CYC + 1);
            end
            chk($sformatf("rr_order%0d", g), {61'b0, gnt}, (g % 2) ? 64'd2 : 64'd1);
            own = gnt;
            repeat (19) tick();
            if (own[0]) req0 = 0;
            if (own[1]) req1 = 0;
            tick();
            req0 = 1; req1 = 1;
        end
        req0 = 0; req1 = 0;

        // Manual preempted by a relock, then regains after guard
        do_reset();
        req_man = 1;
        wait_gnt("man_gnt", 3'b100, 10);
        repeat (50) tick();
        req1 = 1;
        tick();
        count_gap(gap);
        chk("preempt_gap", gap, GUARD_CYC + 1);
        chk("preempt_gnt", {61'b0, gnt}, 64'd2);
        repeat (30) tick();
        chk("preempt_hold", {61'b0, gnt}, 64'd2);
        req1 = 0;
        tick();
        count_gap(gap);
        chk("man_back_gap", gap, GUARD_CYC + 1);
        chk("man_back_gnt", {61'b0, gnt}, 64'd4);
        req_man = 0;

        // Timeout of 100 cycles, clear in the timeout cycle loses
        do_reset();
        tmo_limit = 100; req0 = 1;
        wait_gnt("tmo_gnt", 3'b001, 10);
        cnt = 1;
        while (gnt == 3'b001 && cnt < 150) begin
            if (cnt == 100) clear_flags = 1;
            tick();
            clear_flags = 0;
            if (gnt == 3'b001) cnt++;
        end
        chk("tmo_len", cnt, 100);
        chk("tmo_flag", {62'b0, tmo_flag}, 64'd1);
        bad = 0;
        repeat (60) begin tick(); if (gnt != 3'b000) bad++; end
        chk("tmo_blocked", bad, 0);
        req0 = 0; tick(); req0 = 1;
        wait_gnt("tmo_regrant", 3'b001, 10);
        chk("tmo_flag_kept", {62'b0, tmo_flag}, 64'd1);
        clear_flags = 1; tick(); clear_flags = 0;
        chk("tmo_clear", {62'b0, tmo_flag}, 64'd0);
        req0 = 0;

        // Timeout disabled, long grant, then reset mid-grant
        do_reset();
        tmo_limit = 0; req1 = 1;
        wait_gnt("long_gnt", 3'b010, 10);
        bad = 0;
        repeat (10000) begin tick(); if (gnt != 3'b010) bad++; end
        chk("long_hold", bad, 0);
        chk("long_flag", {62'b0, tmo_flag}, 64'd0);
        rst = 1; tick(); rst = 0;
        chk("midrst_gnt", {61'b0, gnt}, 64'd0);
        chk("midrst_run", {63'b0, ramp_run}, 64'd0);
        chk("midrst_low", ext(ramp_low), 64'd0);
        chk("midrst_hig", ext(ramp_hig), 64'd0);
        req1 = 0;

        // Randomized traffic against the model
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            tmo_limit = (seg == 1) ? '0 : TMO_W'($urandom_range(3, 40));
            repeat (1000) begin
                if ($urandom_range(0, 15) == 0) req0 = ~req0;
                if ($urandom_range(0, 15) == 0) req1 = ~req1;
                if ($urandom_range(0, 23) == 0) req_man = ~req_man;
                if ($urandom_range(0, 7) == 0) low0 = R'($urandom);
                if ($urandom_range(0, 7) == 0) hig1 = R'($urandom);
                if ($urandom_range(0, 7) == 0) low_man = R'($urandom);
                clear_flags = ($urandom_range(0, 19) == 0);
                rst = ($urandom_range(0, 599) == 0);
                tick();
            end
        end
        rst = 0; clear_flags = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
